backward_counter: RTL and testbench

Down-counting step sequencer for the backpropagation phase of the neural network datapath. The forward counter steps layer/neuron indices upward from 0 to TOP. This block walks the same index space in reverse, from TOP down to 0, so weight-update logic can consume error terms in reverse order. It runs a programmable number of sweeps per start, supports consumer back-pressure via `stall`, and reports completion with a one-cycle `done` pulse.

---
 rtl/backward_counter.sv | 65 ++++++
 tb/tb_backward_counter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/backward_counter.sv
// backward_counter: multi-sweep TOP..0 down-counter with stall back-pressure and a one-cycle done pulse
module backward_counter #(
  parameter int WIDTH = 4,
  parameter int TOP = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       epochs,
  input  logic             stall,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             first,
  output logic             last,
  output logic [7:0]       sweeps,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] out_n;
  logic [7:0] sweeps_n;
  logic valid_n, done_n;
  always_comb begin
    state_n = state;
    out_n = out;
    sweeps_n = sweeps;
    if (state == IDLE && start && epochs != 8'd0) begin
      state_n = RUN;
      out_n = WIDTH'(TOP);
      sweeps_n = epochs;
    end else if (state == RUN && !stall) begin
      if (out != '0) out_n = out - 1'b1;
      else if (sweeps > 8'd1) begin
        out_n = WIDTH'(TOP);
        sweeps_n = sweeps - 8'd1;
      end else begin
        state_n = FIN;
        out_n = '0;
        sweeps_n = 8'd0;
      end
    end else if (state == FIN) state_n = IDLE;
    valid_n = state_n == RUN;
    done_n = state_n == FIN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      out <= '0;
      sweeps <= 8'd0;
      valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      out <= out_n;
      sweeps <= sweeps_n;
      valid <= valid_n;
      busy <= valid_n;
      done <= done_n;
    end
  end
  assign first = valid && out == WIDTH'(TOP);
  assign last = valid && out == '0;
endmodule

// File: tb/tb_backward_counter.sv
// tb_backward_counter: directed self-checking bench for backward_counter
module tb_backward_counter;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0;
  logic [7:0] epochs = 8'd0;
  logic [3:0] out;
  logic valid, first, last, busy, done;
  logic [7:0] sweeps;
  int n_chk = 0, n_pass = 0;
  backward_counter #(.WIDTH(4), .TOP(12)) dut (
    .clk(clk), .reset(reset), .start(start), .epochs(epochs), .stall(stall),
    .out(out), .valid(valid), .first(first), .last(last), .sweeps(sweeps),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, ".out"}, out, 0);
    chk({tag, ".valid"}, valid, 0);
    chk({tag, ".first"}, first, 0);
    chk({tag, ".last"}, last, 0);
    chk({tag, ".sweeps"}, sweeps, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
  endtask
  task automatic sweep_chk(input string tag, input int s);
    for (int i = 0; i <= 12; i++) begin
      chk({tag, ".out"}, out, 12 - i);
      chk({tag, ".valid"}, valid, 1);
      chk({tag, ".busy"}, busy, 1);
      chk({tag, ".first"}, first, i == 0);
      chk({tag, ".last"}, last, i == 12);
      chk({tag, ".sweeps"}, sweeps, s);
      chk({tag, ".done"}, done, 0);
      tick();
    end
  endtask
  task automatic done_chk(input string tag);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".valid"}, valid, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".out"}, out, 0);
    tick();
    chk({tag, ".done_once"}, done, 0);
  endtask
  initial begin
    tick();
    reset = 1'b0;
    idle_chk("reset");
    // single sweep
    start = 1'b1; epochs = 8'd1;
    tick();
    start = 1'b0;
    sweep_chk("single", 1);
    done_chk("single");
    idle_chk("single_idle");
    // three sweeps with seamless wrap
    start = 1'b1; epochs = 8'd3;
    tick();
    start = 1'b0;
    for (int s = 3; s >= 1; s--) sweep_chk("multi", s);
    done_chk("multi");
    // five-cycle stall while out is 7
    start = 1'b1; epochs = 8'd1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 18; c++) begin
      chk("stall.out", out, c < 5 ? 12 - c : (c <= 10 ? 7 : 17 - c));
      chk("stall.valid", valid, 1);
      chk("stall.done", done, 0);
      stall = c >= 5 && c <= 9;
      tick();
    end
    stall = 1'b0;
    done_chk("stall");
    // start held high through the run, epochs changed mid-run
    start = 1'b1; epochs = 8'd2;
    tick();
    sweep_chk("ign", 2);
    epochs = 8'd5;
    sweep_chk("ign", 1);
    chk("ign.done", done, 1);
    chk("ign.valid", valid, 0);
    tick();
    chk("ign.idle_valid", valid, 0);
    chk("ign.idle_done", done, 0);
    tick();
    chk("ign.restart_valid", valid, 1);
    chk("ign.restart_sweeps", sweeps, 5);
    chk("ign.restart_out", out, 12);
    start = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_chk("ign_reset");
    // start with zero epochs is ignored
    start = 1'b1; epochs = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("zero.valid", valid, 0);
      chk("zero.done", done, 0);
      chk("zero.busy", busy, 0);
    end
    start = 1'b0;
    // reset mid-run at out=5 in sweep 2
    start = 1'b1; epochs = 8'd2;
    tick();
    start = 1'b0;
    sweep_chk("midrst", 2);
    for (int i = 0; i < 7; i++) tick();
    chk("midrst.out", out, 5);
    chk("midrst.sweeps", sweeps, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_chk("midrst_after");
    tick();
    chk("midrst.no_done", done, 0);
    start = 1'b1; epochs = 8'd1;
    tick();
    start = 1'b0;
    sweep_chk("post_rst", 1);
    done_chk("post_rst");
    // reset and start in the same cycle
    reset = 1'b1; start = 1'b1; epochs = 8'd1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("rst_start.valid", valid, 0);
    tick();
    chk("rst_start.valid2", valid, 0);
    chk("rst_start.busy", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
